// File: rtl/stopwatch_ctrl_59.sv
// stopwatch_ctrl_59
// Run/pause/clear/lap controller for a cascaded BCD mm:ss counter chain.
// A prescaler divides clk down to a count tick while running; each tick
// becomes a one-cycle enable into the chain's least-significant stage.
// The controller also issues the chain clear, the lap-capture strobe for
// the display register, and handles the 59:59 terminal count, either by
// stopping (STOP_AT_MAX=1) or by letting the chain wrap and flagging it.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   btn_start    debounced single-cycle pulse, toggles run/pause
//   btn_clear    debounced single-cycle pulse, clears the chain
//   btn_lap      debounced single-cycle pulse, lap freeze/release
//   max_reached  high while the chain reads 59:59
//   cnt_en       one-cycle enable to the chain's least-significant stage
//   cnt_clr      one-cycle synchronous clear to the whole chain
//   lap_latch    one-cycle capture strobe for the display register
//   disp_hold    level, display shows the latched lap value
//   done         level, high in DONE
//   overflow     sticky, chain wrapped past 59:59 (STOP_AT_MAX=0 only)
//   state        IDLE=00, RUN=01, PAUSE=10, DONE=11
module stopwatch_ctrl_59 #(
  parameter int TICK_DIV    = 50000000,
  parameter bit STOP_AT_MAX = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic       max_reached,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_latch,
  output logic       disp_hold,
  output logic       done,
  output logic       overflow,
  output logic [1:0] state
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  logic [1:0]       state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             cnt_en_reg, cnt_en_next;
  logic             cnt_clr_reg, cnt_clr_next;
  logic             lap_latch_reg, lap_latch_next;
  logic             disp_hold_reg, disp_hold_next;
  logic             overflow_reg, overflow_next;

  // Priority clear > start > lap: a higher-priority button masks the lower
  // ones for that cycle even where the higher one itself has no effect.
  logic start_p;
  logic lap_p;
  assign start_p = btn_start & ~btn_clear;
  assign lap_p   = btn_lap & ~btn_clear & ~btn_start;

  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    cnt_en_next    = 1'b0;
    cnt_clr_next   = 1'b0;
    lap_latch_next = 1'b0;
    disp_hold_next = disp_hold_reg;
    overflow_next  = overflow_reg;

    case (state_reg)
      ST_IDLE: begin
        if (btn_clear) begin
          cnt_clr_next   = 1'b1;
          overflow_next  = 1'b0;
          disp_hold_next = 1'b0;
          div_cnt_next   = '0;
        end else if (start_p) begin
          state_next   = ST_RUN;
          div_cnt_next = '0;
        end
      end

      ST_RUN: begin
        if (start_p) begin
          // Pausing freezes the prescaler so a resume keeps the
          // fractional tick period; no tick is issued this cycle.
          state_next = ST_PAUSE;
        end else begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_next = '0;
            if (!max_reached) begin
              cnt_en_next = 1'b1;
            end else if (STOP_AT_MAX) begin
              // Hold the chain at 59:59 rather than enabling the wrap.
              state_next = ST_DONE;
            end else begin
              cnt_en_next   = 1'b1;
              overflow_next = 1'b1;
            end
          end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
          end

          // Lap is a freeze/release toggle of the display and is
          // independent of the tick path above.
          if (lap_p) begin
            if (!disp_hold_reg) begin
              lap_latch_next = 1'b1;
              disp_hold_next = 1'b1;
            end else begin
              disp_hold_next = 1'b0;
            end
          end
        end
      end

      ST_PAUSE: begin
        if (btn_clear) begin
          cnt_clr_next   = 1'b1;
          overflow_next  = 1'b0;
          disp_hold_next = 1'b0;
          div_cnt_next   = '0;
          state_next     = ST_IDLE;
        end else if (start_p) begin
          state_next = ST_RUN;
        end else if (lap_p) begin
          disp_hold_next = 1'b0;
        end
      end

      default: begin  // ST_DONE
        if (btn_clear) begin
          cnt_clr_next   = 1'b1;
          disp_hold_next = 1'b0;
          div_cnt_next   = '0;
          state_next     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      div_cnt_reg   <= '0;
      cnt_en_reg    <= 1'b0;
      cnt_clr_reg   <= 1'b0;
      lap_latch_reg <= 1'b0;
      disp_hold_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      cnt_en_reg    <= cnt_en_next;
      cnt_clr_reg   <= cnt_clr_next;
      lap_latch_reg <= lap_latch_next;
      disp_hold_reg <= disp_hold_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign cnt_en    = cnt_en_reg;
  assign cnt_clr   = cnt_clr_reg;
  assign lap_latch = lap_latch_reg;
  assign disp_hold = disp_hold_reg;
  assign overflow  = overflow_reg;
  assign done      = (state_reg == ST_DONE);
  assign state     = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl_59.sv
// Testbench for stopwatch_ctrl_59. Instance 0 uses STOP_AT_MAX=1 and
// instance 1 uses STOP_AT_MAX=0, both with TICK_DIV=4. Stimulus pushes
// hand-computed expected output vectors, keyed by clock-edge number, into a
// per-instance queue; a monitor pops and compares on the falling edge
// whenever an entry is due or the DUT raises any pulse output.
module tb_stopwatch_ctrl_59;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      nm;
  } item_t;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] bs  = 2'b00;
  logic [1:0] bc  = 2'b00;
  logic [1:0] bl  = 2'b00;
  logic [1:0] mr  = 2'b00;

  logic [1:0] en_w, clr_w, lap_w, hold_w, done_w, ovf_w;
  logic [1:0] st_w [2];

  int    cyc      = 0;
  int    checks   = 0;
  int    failures = 0;
  item_t sbq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      stopwatch_ctrl_59 #(
        .TICK_DIV   (4),
        .STOP_AT_MAX((gi == 0) ? 1'b1 : 1'b0)
      ) u_dut (
        .clk        (clk),
        .reset      (rst[gi]),
        .btn_start  (bs[gi]),
        .btn_clear  (bc[gi]),
        .btn_lap    (bl[gi]),
        .max_reached(mr[gi]),
        .cnt_en     (en_w[gi]),
        .cnt_clr    (clr_w[gi]),
        .lap_latch  (lap_w[gi]),
        .disp_hold  (hold_w[gi]),
        .done       (done_w[gi]),
        .overflow   (ovf_w[gi]),
        .state      (st_w[gi])
      );
    end
  endgenerate

  // Expected vector layout: {cnt_en, cnt_clr, lap_latch, state[1:0], disp_hold, done, overflow}
  function automatic logic [7:0] mk(input logic en, input logic clr, input logic lap,
                                    input logic [1:0] st, input logic hold,
                                    input logic dn, input logic ovf);
    return {en, clr, lap, st, hold, dn, ovf};
  endfunction

  task automatic push(input int idx, input int c, input logic [7:0] v, input string nm);
    item_t it;
    int    pos;
    it.cyc = c;
    it.v   = v;
    it.nm  = nm;
    pos    = sbq[idx].size();
    for (int i = 0; i < sbq[idx].size(); i++) begin
      if (sbq[idx][i].cyc > c) begin
        pos = i;
        break;
      end
    end
    sbq[idx].insert(pos, it);
  endtask

  // Called on a falling edge; the press is sampled at edge number e.
  task automatic btn(input int idx, input logic s, input logic c, input logic l, output int e);
    e       = cyc + 1;
    bs[idx] = s;
    bc[idx] = c;
    bl[idx] = l;
  endtask

  task automatic rel();
    @(negedge clk);
    bs = 2'b00;
    bc = 2'b00;
    bl = 2'b00;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compares due entries and flags any unexpected pulse.
  always @(negedge clk) begin
    item_t      it;
    logic [7:0] got;
    for (int k = 0; k < 2; k++) begin
      got = {en_w[k], clr_w[k], lap_w[k], st_w[k], hold_w[k], done_w[k], ovf_w[k]};
      while (sbq[k].size() > 0 && sbq[k][0].cyc < cyc) begin
        it = sbq[k].pop_front();
        checks++;
        failures++;
        $display("FAIL dut%0d %s missed at cyc=%0d", k, it.nm, it.cyc);
      end
      if (sbq[k].size() > 0 && sbq[k][0].cyc == cyc) begin
        it = sbq[k].pop_front();
        checks++;
        if (got !== it.v) begin
          failures++;
          $display("FAIL dut%0d %s cyc=%0d got=%b exp=%b", k, it.nm, cyc, got, it.v);
        end else begin
          $display("dut%0d %s cyc=%0d ok vec=%b", k, it.nm, cyc, got);
        end
      end else if ((en_w[k] | clr_w[k] | lap_w[k]) === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL dut%0d unexpected_pulse cyc=%0d got=%b exp=no pulse", k, cyc, got);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    push(0, 2, mk(0, 0, 0, IDLE, 0, 0, 0), "reset_state");
    push(1, 2, mk(0, 0, 0, IDLE, 0, 0, 0), "reset_state");
    goto(3);
    rst[0] = 1'b0;

    // Run: ticks every 4 edges after entering RUN.
    btn(0, 1, 0, 0, e);
    push(0, 4,  mk(0, 0, 0, RUN, 0, 0, 0), "start_run");
    push(0, 8,  mk(1, 0, 0, RUN, 0, 0, 0), "tick1");
    push(0, 12, mk(1, 0, 0, RUN, 0, 0, 0), "tick2");
    push(0, 16, mk(1, 0, 0, RUN, 0, 0, 0), "tick3");
    rel();

    // Pause with prescaler at 2, resume keeps the fraction.
    goto(18);
    btn(0, 1, 0, 0, e);
    push(0, 19, mk(0, 0, 0, PAUSE, 0, 0, 0), "pause");
    push(0, 29, mk(0, 0, 0, PAUSE, 0, 0, 0), "pause_hold");
    rel();
    goto(29);
    btn(0, 1, 0, 0, e);
    push(0, 30, mk(0, 0, 0, RUN, 0, 0, 0), "resume");
    push(0, 32, mk(1, 0, 0, RUN, 0, 0, 0), "resume_tick");
    rel();

    // Lap freeze then release, ticks unaffected.
    goto(32);
    btn(0, 0, 0, 1, e);
    push(0, 33, mk(0, 0, 1, RUN, 1, 0, 0), "lap_latch");
    rel();
    goto(34);
    btn(0, 0, 0, 1, e);
    push(0, 35, mk(0, 0, 0, RUN, 0, 0, 0), "lap_release");
    push(0, 36, mk(1, 0, 0, RUN, 0, 0, 0), "tick_after_lap");
    rel();

    // Terminal count with STOP_AT_MAX=1.
    goto(39);
    mr[0] = 1'b1;
    push(0, 40, mk(0, 0, 0, DONE, 0, 1, 0), "stop_done");
    goto(40);
    mr[0] = 1'b0;
    goto(41);
    btn(0, 1, 0, 0, e);
    push(0, 42, mk(0, 0, 0, DONE, 0, 1, 0), "done_ignores_start");
    rel();
    goto(44);
    btn(0, 0, 1, 0, e);
    push(0, 45, mk(0, 1, 0, IDLE, 0, 0, 0), "done_clear");
    push(0, 47, mk(0, 0, 0, IDLE, 0, 0, 0), "idle_after_clear");
    rel();

    // Clear ignored in RUN; clear beats start in PAUSE.
    goto(47);
    btn(0, 1, 0, 0, e);
    push(0, 48, mk(0, 0, 0, RUN, 0, 0, 0), "restart");
    rel();
    goto(49);
    btn(0, 0, 1, 0, e);
    push(0, 50, mk(0, 0, 0, RUN, 0, 0, 0), "run_ignores_clear");
    push(0, 52, mk(1, 0, 0, RUN, 0, 0, 0), "tick_after_clear");
    rel();
    goto(53);
    btn(0, 1, 0, 0, e);
    push(0, 54, mk(0, 0, 0, PAUSE, 0, 0, 0), "pause2");
    rel();
    goto(56);
    btn(0, 1, 1, 0, e);
    push(0, 57, mk(0, 1, 0, IDLE, 0, 0, 0), "clear_beats_start");
    rel();

    // Reset mid-RUN with disp_hold set.
    goto(59);
    btn(0, 1, 0, 0, e);
    push(0, 60, mk(0, 0, 0, RUN, 0, 0, 0), "start3");
    rel();
    btn(0, 0, 0, 1, e);
    push(0, 61, mk(0, 0, 1, RUN, 1, 0, 0), "lap_before_reset");
    rel();
    rst[0] = 1'b1;
    push(0, 62, mk(0, 0, 0, IDLE, 0, 0, 0), "reset_mid_run");
    goto(62);
    rst[0] = 1'b0;
    push(0, 64, mk(0, 0, 0, IDLE, 0, 0, 0), "idle_after_reset");
    goto(65);
    btn(0, 1, 0, 0, e);
    push(0, 66, mk(0, 0, 0, RUN, 0, 0, 0), "start4");
    push(0, 70, mk(1, 0, 0, RUN, 0, 0, 0), "tick_after_reset");
    rel();
    goto(71);
    btn(0, 1, 0, 0, e);
    push(0, 72, mk(0, 0, 0, PAUSE, 0, 0, 0), "pause4");
    rel();

    // Wrap with STOP_AT_MAX=0: overflow sticky until clear.
    goto(75);
    rst[1] = 1'b0;
    goto(76);
    btn(1, 1, 0, 0, e);
    push(1, 77, mk(0, 0, 0, RUN, 0, 0, 0), "wrap_start");
    push(1, 81, mk(1, 0, 0, RUN, 0, 0, 0), "wrap_tick1");
    push(1, 85, mk(1, 0, 0, RUN, 0, 0, 1), "wrap_overflow");
    rel();
    goto(84);
    mr[1] = 1'b1;
    goto(85);
    mr[1] = 1'b0;
    goto(86);
    btn(1, 1, 0, 0, e);
    push(1, 87, mk(0, 0, 0, PAUSE, 0, 0, 1), "ovf_pause");
    push(1, 95, mk(0, 0, 0, PAUSE, 0, 0, 1), "ovf_sticky");
    rel();
    goto(96);
    btn(1, 0, 1, 0, e);
    push(1, 97, mk(0, 1, 0, IDLE, 0, 0, 0), "ovf_clear");
    push(1, 99, mk(0, 0, 0, IDLE, 0, 0, 0), "idle_after_ovf_clear");
    rel();

    goto(105);
    for (int k = 0; k < 2; k++) begin
      while (sbq[k].size() > 0) begin
        item_t it;
        it = sbq[k].pop_front();
        checks++;
        failures++;
        $display("FAIL dut%0d %s pending cyc=%0d got=never exp=checked", k, it.nm, it.cyc);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl_59.md
Name: stopwatch_ctrl_59

Overview:
Run/pause/clear/lap controller for the cascaded BCD mm:ss (00:00-59:59) counter chain. Divides clk down to a count tick and issues the chain's enable pulse. Issues a synchronous clear pulse to the chain and a lap-capture pulse to the display register. Detects the 59:59 terminal count, then either stops or wraps, per parameter.

Parameters:
TICK_DIV, 50000000, clk cycles per count tick (>=2); prescaler width = clog2(TICK_DIV)
STOP_AT_MAX, 1, 1 = stop in DONE at 59:59; 0 = wrap to 00:00 and set overflow

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btn_start  input  1  debounced single-cycle pulse; toggles run/pause
btn_clear  input  1  debounced single-cycle pulse; clears chain
btn_lap  input  1  debounced single-cycle pulse; lap freeze/release
max_reached  input  1  high while chain reads 59:59 (AND of all stage carries)
cnt_en  output  1  one-cycle enable to the chain's least-significant stage
cnt_clr  output  1  one-cycle synchronous clear to the whole chain
lap_latch  output  1  one-cycle capture strobe for the display register
disp_hold  output  1  level; display shows the latched lap value
done  output  1  level; high in DONE
overflow  output  1  sticky; chain wrapped past 59:59 (STOP_AT_MAX=0 only)
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Single clock domain. Reset is sampled on clk edges only. Reset yields state=IDLE, div_cnt=0, and every output 0. Reset mid-RUN takes effect at the next edge.
- cnt_en, cnt_clr and lap_latch are registered. Each is high for exactly one cycle, in the cycle following the edge where the decision is made.
- Button priority in one cycle: clear > start > lap. A lower-priority button is ignored in the same cycle.
- Prescaler div_cnt:
  - increments only in RUN;
  - holds in PAUSE, so a resume keeps the fractional period;
  - zeroed on IDLE->RUN, on clear, and on reset.
  - In RUN, when div_cnt==TICK_DIV-1: div_cnt<=0 and a tick occurs.
- IDLE:
  - btn_start -> RUN, div_cnt=0.
  - btn_clear -> cnt_clr pulse, overflow<=0, disp_hold<=0; stay in IDLE.
  - btn_lap ignored.
- RUN:
  - btn_start -> PAUSE. No tick is issued that cycle and div_cnt holds.
  - btn_clear ignored.
  - btn_lap with disp_hold=0 -> lap_latch pulse, disp_hold<=1.
  - btn_lap with disp_hold=1 -> disp_hold<=0, no lap_latch.
  - Lap handling never alters ticking.
- Tick in RUN:
  - max_reached=0 -> cnt_en pulse.
  - max_reached=1 and STOP_AT_MAX=1 -> cnt_en suppressed, go to DONE.
  - max_reached=1 and STOP_AT_MAX=0 -> cnt_en pulse (chain wraps), overflow<=1.
- PAUSE:
  - btn_start -> RUN, div_cnt retained.
  - btn_clear -> cnt_clr pulse, overflow<=0, disp_hold<=0, go to IDLE.
  - btn_lap -> disp_hold<=0.
- DONE:
  - done=1; btn_start and btn_lap ignored.
  - btn_clear -> cnt_clr pulse, disp_hold<=0, go to IDLE.
- max_reached is sampled only in tick cycles; its value at other times is don't-care.
- No tick is generated outside RUN. cnt_en and cnt_clr are never high in the same cycle.

Test Plan:
- TICK_DIV=4, reset, then btn_start -> state=01; cnt_en high on cycles 4, 8, 12 after entering RUN, each 1 cycle wide.
- TICK_DIV=4, btn_start at RUN cycle 2 -> PAUSE, no cnt_en for 10 cycles; btn_start again -> next cnt_en exactly 2 RUN cycles later.
- In RUN, btn_lap -> lap_latch 1 cycle, disp_hold=1; cnt_en cadence unchanged; second btn_lap -> disp_hold=0, no lap_latch.
- STOP_AT_MAX=1, max_reached=1 at a tick -> no cnt_en, state=11, done=1; btn_start ignored; btn_clear -> cnt_clr 1 cycle, state=00, done=0.
- STOP_AT_MAX=0, max_reached=1 at a tick -> cnt_en pulses, overflow=1 and stays high through PAUSE; btn_clear in PAUSE -> overflow=0, cnt_clr, state=00.
- btn_clear+btn_start together in PAUSE -> clear wins (state=00, cnt_clr); btn_clear in RUN -> ignored; reset asserted mid-RUN -> all outputs 0, state=00 after the next edge.
